mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the five-stage RISC-V pipeline. It accepts the load/store requests produced by the execution stage (enable, address, funct3, store data, rd fields) and performs them on the byte-serial memory-controller port. It returns sign- or zero-extended load data and passes non-memory results through to write-back. It holds the pipeline via a stall request while an access is in flight.

## Interface
Parameters:
- none (all widths fixed: `AddrLen`/`RegLen` = 32, `RegAddrLen` = 5, `Funct3Len` = 3)

Ports:
- Clock and reset: single clock; reset is synchronous and active-high.
  - clk_in  input  1  clock
  - rst_in  input  1  synchronous active-high reset
- From execution stage:
  - load_enable_i  input  1  memory load requested
  - store_enable_i  input  1  memory store requested
  - load_store_addr_i  input  32  byte address
  - store_data_i  input  32  store data (rs2)
  - funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
  - rd_data_i  input  32  ALU/link result for non-memory ops
  - rd_addr_i  input  5  destination register
  - rd_write_enable_i  input  1  destination write enable
- Memory-controller port:
  - mctl_req_o  output  1  byte access request
  - mctl_wr_o  output  1  1 = write byte, 0 = read byte
  - mctl_addr_o  output  32  byte address
  - mctl_wdata_o  output  8  write byte
  - mctl_rdata_i  input  8  read byte, valid with mctl_valid_i
  - mctl_valid_i  input  1  current byte completed (1-cycle pulse)
- To write-back, forwarding and hazard logic:
  - rd_data_o  output  32  write-back data
  - rd_addr_o  output  5  destination register
  - rd_write_enable_o  output  1  write-back enable
  - stall_req_o  output  1  hold IF/ID/EX and the EX/MEM register
  - misalign_o  output  1  misaligned-access pulse (see Configuration)

## Operation
- Size N: funct3[1:0] = 00 → 1, 01 → 2, 10 → 4. Store uses funct3[1:0] only.
- FSM states IDLE, ACCESS, DONE; byte index idx 0..3; 32-bit byte buffer.
- IDLE, no enable:
  - rd_* = rd_*_i combinationally; stall_req_o = 0.
- IDLE, load or store enable:
  - Latch addr, store data, funct3, rd_addr, rd_write_enable; idx = 0.
  - stall_req_o = 1; rd_write_enable_o = 0; next state ACCESS.
  - If both enables are set, store wins.
- ACCESS:
  - mctl_req_o = 1; mctl_addr_o = addr + idx (32-bit wrap).
  - mctl_wr_o = store; mctl_wdata_o = data[8*idx+7 : 8*idx] (little-endian).
  - On mctl_valid_i: load writes mctl_rdata_i into buffer byte idx; if idx == N−1 go to DONE, else idx + 1.
  - stall_req_o = 1; rd_write_enable_o = 0.
- DONE, one cycle:
  - stall_req_o = 0; inputs ignored (the EX/MEM register still holds the same instruction).
  - Load: rd_data_o = extended buffer; B/H sign-extend from bit 7/15, BU/HU zero-extend. rd_write_enable_o = latched enable && rd_addr != 0.
  - Store: rd_write_enable_o = 0, rd_data_o = 0.
  - Next state IDLE.
- mctl_valid_i is ignored outside ACCESS.

## Timing
- Reset values:
  - state IDLE, idx 0, buffer 0.
  - mctl_req_o 0, mctl_wr_o 0, mctl_addr_o 0, mctl_wdata_o 0.
  - misalign_o 0, registered rd fields 0.
- Reset mid-ACCESS: next cycle IDLE, mctl_req_o dropped, partial access abandoned, no write-back.
- Latency: accept cycle, then N ACCESS bytes at one cycle minimum each, then DONE.
  - LW with mctl_valid_i every cycle: stall_req_o high for 5 cycles, data on rd_data_o in cycle 6 (DONE).
- mctl_valid_i may be asserted in the first ACCESS cycle for a byte; mctl_addr/wdata hold stable until valid.
- Non-memory ops: zero latency, no stall.
- Back-to-back memory ops: the next request is accepted in the IDLE cycle following DONE.

## Configuration
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, an H/HU/SH access with addr[0] = 1, or a W/SW access with addr[1:0] ≠ 00, is not performed.
  - misalign_o pulses high for one cycle and the FSM goes directly to DONE with write-back disabled.
  - stall_req_o is high for the accept cycle only.
- Undefined: misaligned accesses proceed byte-wise as normal; misalign_o is tied 0.

## Test plan
- LW addr 0x1000, bytes 78 56 34 12, valid every cycle → 4 reads at 0x1000..0x1003, rd_data_o = 0x12345678, stall_req_o high for exactly 5 cycles.
- LB 0x2003 byte 0x80 → 0xFFFFFF80; LBU same → 0x00000080; LHU 0x2000 bytes FF 7F → 0x00007FFF.
- SH addr 0x3000, data 0xDEADBEEF, valid delayed 3 cycles per byte → writes EF then BE, addr/wdata stable while waiting, no write-back.
- ADD result 0x55, rd x5, no enables → rd_data_o 0x55, rd_write_enable_o 1 in the same cycle, stall_req_o 0; LW to x0 → write-back disabled.
- rst_in asserted in the 2nd ACCESS cycle of an LW → mctl_req_o 0 the next cycle, IDLE, no write-back; a following LB completes normally.
- With MEM_ALIGN_CHECK_EN: LW 0x1002 → no mctl_req_o, misalign_o one-cycle pulse, rd_write_enable_o 0. Without the macro: bytes fetched from 0x1002..0x1005.

Source files
------------

// File: rtl/mem_access_stage.sv
// RISC-V memory stage: runs loads/stores over a byte-serial controller port and extends load data.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned H/W accesses with a one-cycle misalign_o pulse.
module mem_access_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_enable_i,
  input  logic        store_enable_i,
  input  logic [31:0] load_store_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rd_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_write_enable_i,
  output logic        mctl_req_o,
  output logic        mctl_wr_o,
  output logic [31:0] mctl_addr_o,
  output logic [7:0]  mctl_wdata_o,
  input  logic [7:0]  mctl_rdata_i,
  input  logic        mctl_valid_i,
  output logic [31:0] rd_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_write_enable_o,
  output logic        stall_req_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  logic [31:0] r_buf;
  logic [31:0] r_data;
  logic [31:0] r_mctl_addr;
  logic [7:0]  r_wdata;
  logic        r_req;
  logic        r_wr;
  logic        r_store;
  logic        r_rd_we;
  logic        r_mis;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd_addr;
  logic        w_accept;
  logic        w_mis;

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] i);
    return d[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] b, input logic [2:0] f3);
    logic signed [31:0] s;
    case (f3)
      3'b000:  s = {{24{b[7]}}, b[7:0]};
      3'b001:  s = {{16{b[15]}}, b[15:0]};
      3'b100:  s = {24'd0, b[7:0]};
      3'b101:  s = {16'd0, b[15:0]};
      default: s = b;
    endcase
    return s;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
    return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
  endfunction
  assign w_mis      = misaligned(load_store_addr_i[1:0], funct3_i[1:0]);
  assign misalign_o = r_mis;
`else
  assign w_mis      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign w_accept     = (r_state == IDLE) && (load_enable_i || store_enable_i);
  assign mctl_req_o   = r_req;
  assign mctl_wr_o    = r_wr;
  assign mctl_addr_o  = r_mctl_addr;
  assign mctl_wdata_o = r_wdata;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_last      <= 2'd0;
      r_buf       <= 32'd0;
      r_data      <= 32'd0;
      r_mctl_addr <= 32'd0;
      r_wdata     <= 8'd0;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_store     <= 1'b0;
      r_rd_we     <= 1'b0;
      r_mis       <= 1'b0;
      r_funct3    <= 3'd0;
      r_rd_addr   <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mis <= 1'b0;
          if (w_accept) begin
            r_store   <= store_enable_i;
            r_data    <= store_data_i;
            r_funct3  <= funct3_i;
            r_rd_addr <= rd_addr_i;
            r_rd_we   <= rd_write_enable_i;
            r_idx     <= 2'd0;
            r_last    <= last_idx(funct3_i[1:0]);
            if (w_mis) begin
              r_state <= DONE;
              r_mis   <= 1'b1;
            end else begin
              r_state     <= ACCESS;
              r_req       <= 1'b1;
              r_wr        <= store_enable_i;
              r_mctl_addr <= load_store_addr_i;
              r_wdata     <= store_data_i[7:0];
            end
          end
        end
        ACCESS: begin
          // address and write byte stay put until the controller completes the byte
          if (mctl_valid_i) begin
            if (!r_store) r_buf[{r_idx, 3'b000} +: 8] <= mctl_rdata_i;
            if (r_idx == r_last) begin
              r_state <= DONE;
              r_req   <= 1'b0;
              r_wr    <= 1'b0;
            end else begin
              r_idx       <= r_idx + 2'd1;
              r_mctl_addr <= r_mctl_addr + 32'd1;
              r_wdata     <= byte_sel(r_data, r_idx + 2'd1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_mis   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_o         = rd_data_i;
    rd_addr_o         = rd_addr_i;
    rd_write_enable_o = rd_write_enable_i;
    stall_req_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stall_req_o       = 1'b1;
          rd_write_enable_o = 1'b0;
        end
      end
      ACCESS: begin
        stall_req_o       = 1'b1;
        rd_write_enable_o = 1'b0;
        rd_addr_o         = r_rd_addr;
        rd_data_o         = 32'd0;
      end
      DONE: begin
        rd_addr_o = r_rd_addr;
        if (r_store) begin
          rd_data_o         = 32'd0;
          rd_write_enable_o = 1'b0;
        end else begin
          rd_data_o         = load_extend(r_buf, r_funct3);
          rd_write_enable_o = r_rd_we && (r_rd_addr != 5'd0) && !r_mis;
        end
      end
      default: begin
        stall_req_o       = 1'b0;
        rd_write_enable_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: byte-serial memory responder, expected controller
// transactions and write-backs queued at drive time and compared as the DUT produces them.
module tb_mem_access_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        load_enable_i, store_enable_i;
  logic [31:0] load_store_addr_i, store_data_i;
  logic [2:0]  funct3_i;
  logic [31:0] rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_write_enable_i;
  logic        mctl_req_o, mctl_wr_o;
  logic [31:0] mctl_addr_o;
  logic [7:0]  mctl_wdata_o;
  logic [7:0]  mctl_rdata_i;
  logic        mctl_valid_i;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_write_enable_o, stall_req_o, misalign_o;

  mem_access_stage dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .load_enable_i(load_enable_i), .store_enable_i(store_enable_i),
    .load_store_addr_i(load_store_addr_i), .store_data_i(store_data_i),
    .funct3_i(funct3_i), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
    .rd_write_enable_i(rd_write_enable_i),
    .mctl_req_o(mctl_req_o), .mctl_wr_o(mctl_wr_o), .mctl_addr_o(mctl_addr_o),
    .mctl_wdata_o(mctl_wdata_o), .mctl_rdata_i(mctl_rdata_i), .mctl_valid_i(mctl_valid_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_write_enable_o(rd_write_enable_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [31:0] addr; logic wr; logic [7:0] wdata; } mreq_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; } wb_t;

  mreq_t      mq[$];
  wb_t        wbq[$];
  logic [7:0] mem [logic [31:0]];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rdmem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return 32'($signed(w[7:0]));
      3'b001:  return 32'($signed(w[15:0]));
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic idle_inputs();
    load_enable_i = 0; store_enable_i = 0; rd_write_enable_i = 0;
    load_store_addr_i = 0; store_data_i = 0; funct3_i = 0; rd_data_i = 0; rd_addr_i = 0;
  endtask

  // Presents one memory op (held until DONE) and acts as the byte-serial memory.
  task automatic run_op(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rwe, input int dly, output int stalls, output int reqs,
                        output int mis, output logic wbseen, output logic [31:0] wbdata);
    int n, wcnt;
    logic is_mis, done;
    logic [31:0] word;
    mreq_t m;
    wb_t e;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    is_mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    is_mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`endif
    word = 32'h0;
    if (!is_mis) begin
      for (int k = 0; k < n; k++) begin
        m.addr = addr + k; m.wr = st; m.wdata = sd[8*k +: 8];
        mq.push_back(m);
        word[8*k +: 8] = rdmem(addr + k);
      end
      if (ld && !st && rwe && (rd != 5'd0)) begin
        e.data = ext_model(word, f3); e.rd = rd;
        wbq.push_back(e);
      end
    end
    load_enable_i = ld; store_enable_i = st; load_store_addr_i = addr; store_data_i = sd;
    funct3_i = f3; rd_addr_i = rd; rd_write_enable_i = rwe; rd_data_i = 32'hA5A5A5A5;
    stalls = 0; reqs = 0; mis = 0; wbseen = 0; wbdata = 0; wcnt = 0; done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      #1;
      if (stall_req_o) stalls++;
      if (misalign_o) mis++;
      if (rd_write_enable_o) begin
        wbseen = 1; wbdata = rd_data_o;
        if (wbq.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          e = wbq.pop_front();
          chk("wb_data", rd_data_o, e.data);
          chk("wb_rd", {27'd0, rd_addr_o}, {27'd0, e.rd});
        end
      end
      if (mctl_req_o) begin
        reqs++;
        if (mq.size() == 0) begin
          chk("req_unexpected", 1, 0);
          mctl_valid_i = 0;
        end else begin
          m = mq[0];
          chk("mctl_addr", mctl_addr_o, m.addr);
          chk("mctl_wr", {31'd0, mctl_wr_o}, {31'd0, m.wr});
          if (m.wr) chk("mctl_wdata", {24'd0, mctl_wdata_o}, {24'd0, m.wdata});
          if (wcnt == dly) begin
            mctl_valid_i = 1;
            if (m.wr) mem[m.addr] = mctl_wdata_o;
            else mctl_rdata_i = rdmem(m.addr);
            void'(mq.pop_front());
            wcnt = 0;
          end else begin
            mctl_valid_i = 0;
            wcnt++;
          end
        end
      end else mctl_valid_i = 0;
      if (c > 0 && !stall_req_o) begin
        done = 1;
        load_enable_i = 0; store_enable_i = 0; rd_write_enable_i = 0;
      end
      @(negedge clk_in);
    end
    mctl_valid_i = 0;
    if (!done) chk("op_timeout", 0, 1);
    chk("mq_drained", 32'(mq.size()), 0);
    chk("wbq_drained", 32'(wbq.size()), 0);
  endtask

  initial begin
    int st, rq, ms, n, dly;
    logic wb, ld;
    logic [31:0] wd, a, sd;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [2:0] ld_f3s [5];
    ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst_in = 1; mctl_valid_i = 0; mctl_rdata_i = 0;
    idle_inputs();
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_req", {31'd0, mctl_req_o}, 0);
    chk("rst_wr", {31'd0, mctl_wr_o}, 0);
    chk("rst_addr", mctl_addr_o, 0);
    chk("rst_wdata", {24'd0, mctl_wdata_o}, 0);
    chk("rst_misalign", {31'd0, misalign_o}, 0);
    chk("rst_stall", {31'd0, stall_req_o}, 0);
    rst_in = 0;
    @(negedge clk_in);

    // LW 0x1000, valid every cycle
    mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56; mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
    mem[32'h1004] = 8'hAA; mem[32'h1005] = 8'hBB;
    run_op(1, 0, 32'h1000, 3'b010, 0, 5'd3, 1, 0, st, rq, ms, wb, wd);
    chk("lw_data", wd, 32'h12345678);
    chk("lw_stalls", st, 5);
    chk("lw_reqs", rq, 4);

    // Byte/halfword extension
    mem[32'h2003] = 8'h80; mem[32'h2000] = 8'hFF; mem[32'h2001] = 8'h7F;
    run_op(1, 0, 32'h2003, 3'b000, 0, 5'd4, 1, 0, st, rq, ms, wb, wd);
    chk("lb_data", wd, 32'hFFFFFF80);
    run_op(1, 0, 32'h2003, 3'b100, 0, 5'd4, 1, 1, st, rq, ms, wb, wd);
    chk("lbu_data", wd, 32'h00000080);
    run_op(1, 0, 32'h2000, 3'b101, 0, 5'd6, 1, 0, st, rq, ms, wb, wd);
    chk("lhu_data", wd, 32'h00007FFF);
    run_op(1, 0, 32'h2000, 3'b001, 0, 5'd6, 1, 0, st, rq, ms, wb, wd);
    chk("lh_data", wd, 32'h00007FFF);

    // SH with three wait cycles per byte
    run_op(0, 1, 32'h3000, 3'b001, 32'hDEADBEEF, 5'd8, 1, 3, st, rq, ms, wb, wd);
    chk("sh_byte0", {24'd0, rdmem(32'h3000)}, 32'hEF);
    chk("sh_byte1", {24'd0, rdmem(32'h3001)}, 32'hBE);
    chk("sh_byte2_untouched", {24'd0, rdmem(32'h3002)}, 32'h00);
    chk("sh_stalls", st, 9);
    chk("sh_no_wb", {31'd0, wb}, 0);

    // Both enables: store wins
    run_op(1, 1, 32'h5000, 3'b010, 32'hCAFEF00D, 5'd9, 1, 0, st, rq, ms, wb, wd);
    chk("both_store_b3", {24'd0, rdmem(32'h5003)}, 32'hCA);
    chk("both_no_wb", {31'd0, wb}, 0);

    // Non-memory op passes straight through
    rd_data_i = 32'h55; rd_addr_i = 5'd5; rd_write_enable_i = 1;
    #1;
    chk("alu_data", rd_data_o, 32'h55);
    chk("alu_we", {31'd0, rd_write_enable_o}, 1);
    chk("alu_rd", {27'd0, rd_addr_o}, 5);
    chk("alu_stall", {31'd0, stall_req_o}, 0);
    @(negedge clk_in);
    idle_inputs();

    // LW to x0 is never written back
    run_op(1, 0, 32'h1000, 3'b010, 0, 5'd0, 1, 0, st, rq, ms, wb, wd);
    chk("lw_x0_no_wb", {31'd0, wb}, 0);

    // Reset in the second ACCESS cycle of an LW
    load_enable_i = 1; load_store_addr_i = 32'h1000; funct3_i = 3'b010;
    rd_addr_i = 5'd7; rd_write_enable_i = 1;
    #1;
    chk("rst_mid_accept_stall", {31'd0, stall_req_o}, 1);
    @(negedge clk_in); #1;
    chk("rst_mid_req1", {31'd0, mctl_req_o}, 1);
    mctl_valid_i = 1; mctl_rdata_i = rdmem(32'h1000);
    @(negedge clk_in); #1;
    chk("rst_mid_req2", {31'd0, mctl_req_o}, 1);
    chk("rst_mid_addr2", mctl_addr_o, 32'h1001);
    mctl_valid_i = 0; rst_in = 1;
    load_enable_i = 0; rd_write_enable_i = 0;
    @(negedge clk_in); #1;
    chk("rst_mid_req_drop", {31'd0, mctl_req_o}, 0);
    chk("rst_mid_stall", {31'd0, stall_req_o}, 0);
    chk("rst_mid_no_wb", {31'd0, rd_write_enable_o}, 0);
    rst_in = 0;
    @(negedge clk_in); #1;
    chk("rst_mid_idle", {31'd0, mctl_req_o}, 0);
    @(negedge clk_in);
    idle_inputs();
    run_op(1, 0, 32'h2003, 3'b000, 0, 5'd10, 1, 0, st, rq, ms, wb, wd);
    chk("post_rst_lb", wd, 32'hFFFFFF80);

    // Misaligned word load
    run_op(1, 0, 32'h1002, 3'b010, 0, 5'd11, 1, 0, st, rq, ms, wb, wd);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_reqs", rq, 0);
    chk("mis_pulse", ms, 1);
    chk("mis_no_wb", {31'd0, wb}, 0);
    chk("mis_stalls", st, 1);
`else
    chk("mis_reqs", rq, 4);
    chk("mis_pulse", ms, 0);
    chk("mis_data", wd, 32'hBBAA1234);
`endif

    // Randomised aligned traffic
    for (int i = 0; i < 256; i++) mem[32'h4000 + i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? ld_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      a = 32'h4000 + 32'($urandom_range(0, 63)) * 4;
      if (n == 1) a = a + 32'($urandom_range(0, 3));
      else if (n == 2) a = a + 32'($urandom_range(0, 1)) * 2;
      sd = $urandom; rd = 5'($urandom_range(0, 31)); dly = $urandom_range(0, 2);
      run_op(ld, !ld, a, f3, sd, rd, 1, dly, st, rq, ms, wb, wd);
      chk("rnd_stalls", st, 1 + n * (dly + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
